buffer_w_pingpong: RTL and testbench
====================================

Name: buffer_w_pingpong

Overview:
Double-buffered weight buffer for the MM engine. Two regions, each 2**BUFFER_ADDR_WIDTH words deep, sit in one simple-dual-port RAM. The load path fills one region while the MM path reads the other, and a done/release handshake swaps ownership. This lets weight load of tile N+1 overlap compute on tile N.

Parameters:
BUFFER_ADDR_WIDTH, 13, word address width within one region; physical depth is 2*2**BUFFER_ADDR_WIDTH.
BUFFER_DATA_WIDTH, 8192, word width in bits.
READ_LATENCY, 2, RAM read latency in cycles; must be >= 1.
MEM_POOL_PRIMITIVE, "ultra", RAM primitive: "ultra", "b", "d" or "auto".

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
load_write_addr_valid  in  1  write strobe for the current load region.
load_write_addr  in  BUFFER_ADDR_WIDTH  word address within the load region.
load_write_data  in  BUFFER_DATA_WIDTH  write data.
load_done  in  1  one-cycle pulse: load region complete, hand it to MM.
load_ready  out  1  load region is free to be written.
mm_read_addr_valid  in  1  read strobe for the current MM region.
mm_read_addr  in  BUFFER_ADDR_WIDTH  word address within the MM region.
mm_read_data_valid  out  1  read data valid.
mm_read_data  out  BUFFER_DATA_WIDTH  read data; zero when not valid.
mm_ready  out  1  MM region holds a completed tile.
mm_release  in  1  one-cycle pulse: MM finished with its region.
err_sticky  out  2  bit0: write/load_done while !load_ready; bit1: read/mm_release while !mm_ready.

Behaviour:
- State: full[1:0], load_ptr and mm_ptr (1 bit each). Reset values: all 0.
- Combinational outputs: load_ready = ~full[load_ptr]; mm_ready = full[mm_ptr].
- Physical address is {ptr, addr}, with the pointer sampled in the cycle of the request.
- Write path: 1-cycle input register, then RAM write.
  - Accepted only when load_write_addr_valid && load_ready.
  - Otherwise the write is dropped and err_sticky[0] is set.
- load_done with load_ready: full[load_ptr] <= 1 and load_ptr toggles next cycle. Without load_ready: ignored, err_sticky[0] set.
- A write in the same cycle as an accepted load_done goes to the old region, so it is part of the completed tile.
- Read path: 1-cycle input register, then READ_LATENCY RAM cycles, then 1-cycle output register.
  - Total latency is READ_LATENCY+2 cycles, 4 at the default.
  - Fully pipelined: one read per cycle, in order.
- Reads are accepted only when mm_read_addr_valid && mm_ready.
  - A rejected read produces no valid beat and sets err_sticky[1].
- RAM read enable equals the registered accept; the valid shift register tracks accepts exactly.
- mm_read_data holds 0 whenever mm_read_data_valid is 0.
- mm_release with mm_ready: full[mm_ptr] <= 0 and mm_ptr toggles.
  - Reads already in flight complete with data from the old region.
  - A read in the same cycle as the release is accepted against the old region.
  - Without mm_ready, mm_release is ignored and err_sticky[1] is set.
- Simultaneous accepted load_done and mm_release:
  - They always target different regions, since one needs full=0 and the other full=1.
  - Both take effect in the same cycle.
- Both regions full: load_ready = 0 until mm_release.
- Both regions empty: mm_ready = 0.
- Addresses wrap naturally within a region; there is no cross-region access.
- RAM write mode is read_first. A same-address read and write cannot occur, because the two ports always use different regions.
- Reset mid-operation, on the next edge:
  - Flags, pointers and err_sticky clear.
  - The read valid pipeline flushes, so no valid beat follows reset.
  - Pending writes are discarded.
  - RAM contents are undefined.
- err_sticky clears only on rst.

Optional Feature:
BUFFER_W_PINGPONG_STATS_EN
- Defined: adds outputs stat_write_cnt, stat_read_cnt and stat_drop_cnt, each 32 bits. They count accepted writes, accepted reads, and dropped writes/reads/handshakes. Counters saturate at 2**32-1 and clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan (BUFFER_ADDR_WIDTH=4, BUFFER_DATA_WIDTH=32, READ_LATENCY=2):
- After reset, write addr 0..15 with data 0xA0+i, pulse load_done -> next cycle mm_ready=1, load_ready=1. Read addr 3 -> valid exactly 4 cycles later with 0xA3.
- Overlap: while reading region 0, load region 1 with 0xB0+i and pulse load_done -> full=2'b11, load_ready=0. Pulse mm_release -> mm_ready stays 1. Read addr 3 -> 0xB3.
- Back-to-back reads addr 0..15 over 16 cycles, mm_release in the cycle of the last read -> 16 consecutive valid beats 0xA0..0xAF, none dropped.
- Write with load_ready=0 and read with mm_ready=0 -> err_sticky=2'b11, no RAM change, no valid beat. Prior data is intact on a subsequent legal read.
- Assert rst for one cycle while 3 reads are in flight -> mm_read_data_valid=0 for the following 6 cycles, mm_ready=0, load_ready=1, err_sticky=0.
- With BUFFER_W_PINGPONG_STATS_EN: after the first scenario plus 2 dropped writes -> stat_write_cnt=16, stat_read_cnt=1, stat_drop_cnt=2.

Source files
------------

// File: rtl/buffer_w_pingpong.sv
// buffer_w_pingpong: double-buffered weight buffer for the MM engine.
// Two regions share one simple-dual-port RAM. The load side fills one region
// while the MM side reads the other, and load_done / mm_release swap ownership.
// Optional build macro BUFFER_W_PINGPONG_STATS_EN adds saturating
// accepted-write, accepted-read and drop counters.
module buffer_w_pingpong #(
    parameter int    BUFFER_ADDR_WIDTH  = 13,
    parameter int    BUFFER_DATA_WIDTH  = 8192,
    parameter int    READ_LATENCY       = 2,
    parameter string MEM_POOL_PRIMITIVE = "ultra"
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_write_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
    input  logic                         load_done,
    output logic                         load_ready,
    input  logic                         mm_read_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
    output logic                         mm_read_data_valid,
    output logic [BUFFER_DATA_WIDTH-1:0] mm_read_data,
    output logic                         mm_ready,
    input  logic                         mm_release,
    output logic [1:0]                   err_sticky
`ifdef BUFFER_W_PINGPONG_STATS_EN
    ,
    output logic [31:0]                  stat_write_cnt,
    output logic [31:0]                  stat_read_cnt,
    output logic [31:0]                  stat_drop_cnt
`endif
);

    // Physical address carries the region pointer as its MSB.
    localparam int PHYS_AW = BUFFER_ADDR_WIDTH + 1;
    localparam int DEPTH   = 2 ** PHYS_AW;

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       load_ptr;
    logic       mm_ptr;

    logic       wr_acc;
    logic       ld_acc;
    logic       rd_acc;
    logic       rel_acc;
    logic       wr_drop;
    logic       ld_drop;
    logic       rd_drop;
    logic       rel_drop;

    logic                         wr_vld_q;
    logic [PHYS_AW-1:0]           wr_addr_q;
    logic [BUFFER_DATA_WIDTH-1:0] wr_data_q;

    logic                         rd_acc_q;
    logic [PHYS_AW-1:0]           rd_addr_q;
    logic [BUFFER_DATA_WIDTH-1:0] ram_rd_q;
    logic [BUFFER_DATA_WIDTH-1:0] ram_dout;
    logic [READ_LATENCY-1:0]      ram_vld_sr;

    assign load_ready = ~full[load_ptr];
    assign mm_ready   = full[mm_ptr];

    assign wr_acc   = load_write_addr_valid & load_ready;
    assign ld_acc   = load_done & load_ready;
    assign rd_acc   = mm_read_addr_valid & mm_ready;
    assign rel_acc  = mm_release & mm_ready;
    assign wr_drop  = load_write_addr_valid & ~load_ready;
    assign ld_drop  = load_done & ~load_ready;
    assign rd_drop  = mm_read_addr_valid & ~mm_ready;
    assign rel_drop = mm_release & ~mm_ready;

    // Next fill state; an accepted load_done and mm_release always hit different regions.
    always_comb begin
        full_nxt = full;
        if (ld_acc) begin
            full_nxt[load_ptr] = 1'b1;
        end
        if (rel_acc) begin
            full_nxt[mm_ptr] = 1'b0;
        end
    end

    // Ownership flags, region pointers and sticky protocol errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= 2'b00;
            load_ptr   <= 1'b0;
            mm_ptr     <= 1'b0;
            err_sticky <= 2'b00;
        end else begin
            full <= full_nxt;
            if (ld_acc) begin
                load_ptr <= ~load_ptr;
            end
            if (rel_acc) begin
                mm_ptr <= ~mm_ptr;
            end
            err_sticky <= err_sticky | {rd_drop | rel_drop, wr_drop | ld_drop};
        end
    end

    // Write input register; the region pointer is captured with the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q <= 1'b0;
        end else begin
            wr_vld_q <= wr_acc;
        end
        wr_addr_q <= {load_ptr, load_write_addr};
        wr_data_q <= load_write_data;
    end

    // Read input register; the registered accept doubles as RAM read enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_acc_q <= 1'b0;
        end else begin
            rd_acc_q <= rd_acc;
        end
        rd_addr_q <= {mm_ptr, mm_read_addr};
    end

    // RAM array with primitive hint; read_first because ports never share a region.
    if (MEM_POOL_PRIMITIVE == "ultra") begin : g_ram
        (* ram_style = "ultra" *) logic [BUFFER_DATA_WIDTH-1:0] mem [DEPTH];
        // Write port (pending write suppressed on reset) and first read stage.
        always_ff @(posedge clk) begin
            if (wr_vld_q && !rst) begin
                mem[wr_addr_q] <= wr_data_q;
            end
            if (rd_acc_q) begin
                ram_rd_q <= mem[rd_addr_q];
            end
        end
    end else if (MEM_POOL_PRIMITIVE == "b") begin : g_ram
        (* ram_style = "block" *) logic [BUFFER_DATA_WIDTH-1:0] mem [DEPTH];
        // Write port (pending write suppressed on reset) and first read stage.
        always_ff @(posedge clk) begin
            if (wr_vld_q && !rst) begin
                mem[wr_addr_q] <= wr_data_q;
            end
            if (rd_acc_q) begin
                ram_rd_q <= mem[rd_addr_q];
            end
        end
    end else if (MEM_POOL_PRIMITIVE == "d") begin : g_ram
        (* ram_style = "distributed" *) logic [BUFFER_DATA_WIDTH-1:0] mem [DEPTH];
        // Write port (pending write suppressed on reset) and first read stage.
        always_ff @(posedge clk) begin
            if (wr_vld_q && !rst) begin
                mem[wr_addr_q] <= wr_data_q;
            end
            if (rd_acc_q) begin
                ram_rd_q <= mem[rd_addr_q];
            end
        end
    end else begin : g_ram
        logic [BUFFER_DATA_WIDTH-1:0] mem [DEPTH];
        // Write port (pending write suppressed on reset) and first read stage.
        always_ff @(posedge clk) begin
            if (wr_vld_q && !rst) begin
                mem[wr_addr_q] <= wr_data_q;
            end
            if (rd_acc_q) begin
                ram_rd_q <= mem[rd_addr_q];
            end
        end
    end

    // Remaining RAM output stages beyond the first, when READ_LATENCY > 1.
    if (READ_LATENCY > 1) begin : g_lat
        logic [BUFFER_DATA_WIDTH-1:0] stage [READ_LATENCY-1];
        // Plain delay line carrying RAM data toward the output register.
        always_ff @(posedge clk) begin
            stage[0] <= ram_rd_q;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                stage[i] <= stage[i-1];
            end
        end
        assign ram_dout = stage[READ_LATENCY-2];
    end else begin : g_lat
        assign ram_dout = ram_rd_q;
    end

    // Valid shift register tracks accepted reads through the RAM stages; flushed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_vld_sr <= '0;
        end else begin
            ram_vld_sr <= (ram_vld_sr << 1) | READ_LATENCY'(rd_acc_q);
        end
    end

    // Output register; data is forced to zero on cycles without a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            mm_read_data_valid <= 1'b0;
            mm_read_data       <= '0;
        end else begin
            mm_read_data_valid <= ram_vld_sr[READ_LATENCY-1];
            mm_read_data       <= ram_vld_sr[READ_LATENCY-1] ? ram_dout : '0;
        end
    end

`ifdef BUFFER_W_PINGPONG_STATS_EN
    logic [2:0] drop_inc;

    assign drop_inc = 3'(wr_drop) + 3'(ld_drop) + 3'(rd_drop) + 3'(rel_drop);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_write_cnt <= '0;
            stat_read_cnt  <= '0;
            stat_drop_cnt  <= '0;
        end else begin
            stat_write_cnt <= sat_add(stat_write_cnt, 3'(wr_acc));
            stat_read_cnt  <= sat_add(stat_read_cnt, 3'(rd_acc));
            stat_drop_cnt  <= sat_add(stat_drop_cnt, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_buffer_w_pingpong.sv
// tb_buffer_w_pingpong: directed bench for buffer_w_pingpong with
// BUFFER_ADDR_WIDTH=4, BUFFER_DATA_WIDTH=32, READ_LATENCY=2.
// Honours BUFFER_W_PINGPONG_STATS_EN when the design is built with it.
module tb_buffer_w_pingpong;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_write_addr_valid = 1'b0;
    logic [3:0]  load_write_addr = '0;
    logic [31:0] load_write_data = '0;
    logic        load_done = 1'b0;
    logic        load_ready;
    logic        mm_read_addr_valid = 1'b0;
    logic [3:0]  mm_read_addr = '0;
    logic        mm_read_data_valid;
    logic [31:0] mm_read_data;
    logic        mm_ready;
    logic        mm_release = 1'b0;
    logic [1:0]  err_sticky;
`ifdef BUFFER_W_PINGPONG_STATS_EN
    logic [31:0] stat_write_cnt;
    logic [31:0] stat_read_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    buffer_w_pingpong #(
        .BUFFER_ADDR_WIDTH (4),
        .BUFFER_DATA_WIDTH (32),
        .READ_LATENCY      (2),
        .MEM_POOL_PRIMITIVE("ultra")
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_write_addr_valid(load_write_addr_valid),
        .load_write_addr      (load_write_addr),
        .load_write_data      (load_write_data),
        .load_done            (load_done),
        .load_ready           (load_ready),
        .mm_read_addr_valid   (mm_read_addr_valid),
        .mm_read_addr         (mm_read_addr),
        .mm_read_data_valid   (mm_read_data_valid),
        .mm_read_data         (mm_read_data),
        .mm_ready             (mm_ready),
        .mm_release           (mm_release),
        .err_sticky           (err_sticky)
`ifdef BUFFER_W_PINGPONG_STATS_EN
        ,
        .stat_write_cnt       (stat_write_cnt),
        .stat_read_cnt        (stat_read_cnt),
        .stat_drop_cnt        (stat_drop_cnt)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic ld, input logic rv, input logic [3:0] ra,
                                 input logic rel);
        load_write_addr_valid = wv;
        load_write_addr       = wa;
        load_write_data       = wd;
        load_done             = ld;
        mm_read_addr_valid    = rv;
        mm_read_addr          = ra;
        mm_release            = rel;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Fill the current load region with base+i and complete it on the last write.
    task automatic loadRegion(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), base + 32'(i), i == 15, 1'b0, 4'd0, 1'b0);
            tick();
        end
        idle();
    endtask

    // Issue one read and watch a bounded window for its beat(s).
    task automatic readOne(input logic [3:0] addr, output int lat, output logic [31:0] data,
                           output int beats);
        lat   = 0;
        data  = '0;
        beats = 0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, addr, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) idle();
            if (mm_read_data_valid) begin
                beats++;
                if (lat == 0) begin
                    lat  = k;
                    data = mm_read_data;
                end
            end
        end
    endtask

    initial begin
        int          lat;
        int          beats;
        logic [31:0] data;
        int          first;
        int          last;
        int          nbeats;
        logic [31:0] got [16];
        int          vcount;

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_mm_ready", 32'(mm_ready), 32'd0);
        checkOutput("rst_err", 32'(err_sticky), 32'd0);
        checkOutput("rst_valid", 32'(mm_read_data_valid), 32'd0);
        checkOutput("rst_data", mm_read_data, 32'd0);

        // Fill region 0 and read one word back
        loadRegion(32'hA0);
        checkOutput("s1_mm_ready", 32'(mm_ready), 32'd1);
        checkOutput("s1_load_ready", 32'(load_ready), 32'd1);
        readOne(4'd3, lat, data, beats);
        checkOutput("s1_latency", 32'(lat), 32'd4);
        checkOutput("s1_data", data, 32'hA3);
        checkOutput("s1_beats", 32'(beats), 32'd1);
`ifdef BUFFER_W_PINGPONG_STATS_EN
        checkOutput("s1_stat_wr", stat_write_cnt, 32'd16);
        checkOutput("s1_stat_rd", stat_read_cnt, 32'd1);
        checkOutput("s1_stat_drop", stat_drop_cnt, 32'd0);
`endif

        // Fill region 1 while region 0 is still owned by MM
        loadRegion(32'hB0);
        checkOutput("s2_load_ready", 32'(load_ready), 32'd0);
        checkOutput("s2_mm_ready", 32'(mm_ready), 32'd1);

        // Back-to-back reads of region 0 with release on the last one
        first  = -1;
        last   = -1;
        nbeats = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'(c), c == 15);
            else idle();
            tick();
            if (mm_read_data_valid) begin
                if (nbeats < 16) got[nbeats] = mm_read_data;
                if (first < 0) first = c;
                last = c;
                nbeats++;
            end
        end
        checkOutput("s3_beats", 32'(nbeats), 32'd16);
        checkOutput("s3_first", 32'(first), 32'd3);
        checkOutput("s3_last", 32'(last), 32'd18);
        for (int j = 0; j < 16; j++) begin
            checkOutput($sformatf("s3_data%0d", j), got[j], 32'hA0 + 32'(j));
        end
        checkOutput("s3_mm_ready", 32'(mm_ready), 32'd1);
        checkOutput("s3_load_ready", 32'(load_ready), 32'd1);
        readOne(4'd3, lat, data, beats);
        checkOutput("s3_b_latency", 32'(lat), 32'd4);
        checkOutput("s3_b_data", data, 32'hB3);

        // Release region 1, then try an illegal read with both regions empty
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        tick();
        idle();
        checkOutput("s4_mm_ready_empty", 32'(mm_ready), 32'd0);
        readOne(4'd5, lat, data, beats);
        checkOutput("s4_drop_rd_beats", 32'(beats), 32'd0);
        checkOutput("s4_err_rd", 32'(err_sticky), 32'd2);

        // Fill both regions, then an illegal write plus load_done
        loadRegion(32'hC0);
        loadRegion(32'hD0);
        checkOutput("s4_load_ready_full", 32'(load_ready), 32'd0);
        checkOutput("s4_err_kept", 32'(err_sticky), 32'd2);
        applyStimulus(1'b1, 4'd3, 32'h0000_00FF, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        idle();
        checkOutput("s4_err_both", 32'(err_sticky), 32'd3);
        checkOutput("s4_load_ready_kept", 32'(load_ready), 32'd0);
        checkOutput("s4_mm_ready_kept", 32'(mm_ready), 32'd1);
`ifdef BUFFER_W_PINGPONG_STATS_EN
        checkOutput("s4_stat_wr", stat_write_cnt, 32'd64);
        checkOutput("s4_stat_rd", stat_read_cnt, 32'd18);
        checkOutput("s4_stat_drop", stat_drop_cnt, 32'd3);
`endif
        readOne(4'd3, lat, data, beats);
        checkOutput("s4_intact_latency", 32'(lat), 32'd4);
        checkOutput("s4_intact_data", data, 32'hC3);

        // Reset while three reads are in flight
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'(r), 1'b0);
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("s5_mm_ready", 32'(mm_ready), 32'd0);
        checkOutput("s5_load_ready", 32'(load_ready), 32'd1);
        checkOutput("s5_err", 32'(err_sticky), 32'd0);
        vcount = 0;
        if (mm_read_data_valid) vcount++;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mm_read_data_valid) vcount++;
        end
        checkOutput("s5_no_valid", 32'(vcount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
